// File: rtl/conv_pkg.sv
// ============================================================================
// Module      : conv_pkg
// Description : Shared types and helpers for the multi-filter 1-D convolution
//               engine: FSM state encoding, default parameter values and a
//               width-generic saturating adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_pkg;

    localparam int c_DATA_WIDTH      = 8;
    localparam int c_ACC_WIDTH       = 20;
    localparam int c_NUM_FILTERS     = 4;
    localparam int c_MAX_FILTER_SIZE = 8;
    localparam int c_STRIDE_WIDTH    = 4;

    // Wide enough to hold any ACC_WIDTH sum plus one carry bit.
    localparam int c_CALC_WIDTH      = 64;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_MAC  = 3'd2,
        ST_PSUM = 3'd3,
        ST_OUT  = 3'd4
    } conv_state_e;

    // Adds two sign-extended operands; when sat_en is set the result is
    // clamped to the signed range of 'width' bits, otherwise the caller's
    // truncation to 'width' bits yields two's-complement wrap.
    function automatic logic signed [c_CALC_WIDTH-1:0] sat_add(
        input logic signed [c_CALC_WIDTH-1:0] a,
        input logic signed [c_CALC_WIDTH-1:0] b,
        input int unsigned                    width,
        input logic                           sat_en
    );
        logic signed [c_CALC_WIDTH-1:0] sum;
        logic signed [c_CALC_WIDTH-1:0] hi;
        logic signed [c_CALC_WIDTH-1:0] lo;
        sum = a + b;
        hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        if (sat_en && (sum > hi)) begin
            return hi;
        end
        if (sat_en && (sum < lo)) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_mac_lane.sv
// ============================================================================
// Module      : conv_mac_lane
// Description : One filter lane: tap storage, signed MAC accumulator and psum
//               addition. Saturating arithmetic when CONV_SAT_EN is defined,
//               two's-complement wrap otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_mac_lane
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH      = c_DATA_WIDTH,
    parameter int ACC_WIDTH       = c_ACC_WIDTH,
    parameter int MAX_FILTER_SIZE = c_MAX_FILTER_SIZE
)(
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 tap_wen,
    input  logic [$clog2(MAX_FILTER_SIZE)-1:0]   tap_addr,
    input  logic signed [DATA_WIDTH-1:0]         tap_data,
    input  logic                                 clear,
    input  logic                                 mac_en,
    input  logic [$clog2(MAX_FILTER_SIZE)-1:0]   tap_sel,
    input  logic signed [DATA_WIDTH-1:0]         x_data,
    input  logic                                 psum_en,
    input  logic signed [ACC_WIDTH-1:0]          psum_data,
    output logic signed [ACC_WIDTH-1:0]          acc
);

`ifdef CONV_SAT_EN
    localparam logic c_SAT_EN = 1'b1;
`else
    localparam logic c_SAT_EN = 1'b0;
`endif

    logic signed [DATA_WIDTH-1:0]     r_taps [MAX_FILTER_SIZE];
    logic signed [ACC_WIDTH-1:0]      r_acc;
    logic signed [2*DATA_WIDTH-1:0]   w_prod;
    logic signed [c_CALC_WIDTH-1:0]   w_acc_ext;
    logic signed [c_CALC_WIDTH-1:0]   w_addend;

    assign w_prod    = x_data * r_taps[tap_sel];
    assign w_acc_ext = {{(c_CALC_WIDTH-ACC_WIDTH){r_acc[ACC_WIDTH-1]}}, r_acc};
    assign acc       = r_acc;

    // Tap storage survives reset so weights need not be reloaded after an abort.
    always_ff @(posedge clk) begin
        if (tap_wen) begin
            r_taps[tap_addr] <= tap_data;
        end
    end

    // Select the operand added this cycle: tap product during MAC, psum otherwise.
    always_comb begin
        w_addend = '0;
        if (mac_en) begin
            w_addend = {{(c_CALC_WIDTH-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};
        end else begin
            w_addend = {{(c_CALC_WIDTH-ACC_WIDTH){psum_data[ACC_WIDTH-1]}}, psum_data};
        end
    end

    // Accumulator: cleared at window start, updated on MAC or psum beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (clear) begin
            r_acc <= '0;
        end else if (mac_en || psum_en) begin
            r_acc <= ACC_WIDTH'(sat_add(w_acc_ext, w_addend, ACC_WIDTH, c_SAT_EN));
        end
    end

endmodule

`default_nettype wire

// File: rtl/conv1d_multi_filter_engine.sv
// ============================================================================
// Module      : conv1d_multi_filter_engine
// Description : Streams one IFmap row through a sliding window and evaluates
//               NUM_FILTERS 1-D convolutions in parallel, with optional psum
//               accumulation and a serialised valid/ready result stream.
//               Optional macro: CONV_SAT_EN (saturating accumulation).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv1d_multi_filter_engine
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH      = c_DATA_WIDTH,
    parameter int ACC_WIDTH       = c_ACC_WIDTH,
    parameter int NUM_FILTERS     = c_NUM_FILTERS,
    parameter int MAX_FILTER_SIZE = c_MAX_FILTER_SIZE,
    parameter int STRIDE_WIDTH    = c_STRIDE_WIDTH
)(
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [STRIDE_WIDTH-1:0]              stride,
    input  logic [$clog2(MAX_FILTER_SIZE):0]     filter_size,
    input  logic                                 psum_mode,
    input  logic                                 filt_wen,
    input  logic [$clog2(NUM_FILTERS)-1:0]       filt_idx,
    input  logic [$clog2(MAX_FILTER_SIZE)-1:0]   filt_tap,
    input  logic signed [DATA_WIDTH-1:0]         filt_data,
    input  logic signed [DATA_WIDTH-1:0]         ifmap_data,
    input  logic                                 ifmap_valid,
    input  logic                                 ifmap_last,
    output logic                                 ifmap_ready,
    input  logic signed [ACC_WIDTH-1:0]          psum_data,
    input  logic                                 psum_valid,
    output logic                                 psum_ready,
    output logic signed [ACC_WIDTH-1:0]          result_data,
    output logic [$clog2(NUM_FILTERS)-1:0]       result_idx,
    output logic                                 result_valid,
    input  logic                                 result_ready,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 error
);

    localparam int c_FSW  = $clog2(MAX_FILTER_SIZE) + 1;
    localparam int c_TAPW = $clog2(MAX_FILTER_SIZE);
    localparam int c_IDXW = $clog2(NUM_FILTERS);

    conv_state_e                   r_state;
    conv_state_e                   w_next;

    logic signed [DATA_WIDTH-1:0]  r_win [MAX_FILTER_SIZE];
    logic [c_FSW-1:0]              r_fs;
    logic [STRIDE_WIDTH-1:0]       r_stride;
    logic                          r_psum_mode;
    logic [c_FSW-1:0]              r_fill;
    logic [STRIDE_WIDTH-1:0]       r_skip;
    logic [c_TAPW-1:0]             r_tap;
    logic [c_IDXW-1:0]             r_idx;
    logic                          r_row_last;
    logic                          r_done;
    logic                          r_error;

    logic                          w_cfg_ok;
    logic                          w_accept;
    logic [c_FSW-1:0]              w_fill_nxt;
    logic [STRIDE_WIDTH-1:0]       w_skip_nxt;
    logic                          w_win_done;
    logic                          w_tap_last;
    logic                          w_idx_last;
    logic [c_TAPW-1:0]             w_win_idx;
    logic signed [DATA_WIDTH-1:0]  w_x;
    logic                          w_filt_we;
    logic                          w_clear;
    logic                          w_mac_en;
    logic                          w_psum_en;
    logic                          w_done_set;
    logic signed [ACC_WIDTH-1:0]   w_acc [NUM_FILTERS];

    assign w_cfg_ok   = (stride != '0) && (filter_size != '0) &&
                        (filter_size <= c_FSW'(MAX_FILTER_SIZE));
    assign w_accept   = (r_state == ST_FILL) && ifmap_valid;
    assign w_fill_nxt = (r_fill == r_fs) ? r_fs : r_fill + 1'b1;
    assign w_skip_nxt = (r_skip != '0) ? r_skip - 1'b1 : '0;
    assign w_win_done = w_accept && (w_fill_nxt == r_fs) && (w_skip_nxt == '0);
    assign w_tap_last = ({1'b0, r_tap} == (r_fs - 1'b1));
    assign w_idx_last = (r_idx == c_IDXW'(NUM_FILTERS - 1));

    // Newest element sits at index 0, so tap t reads the (fs-1-t)-th entry.
    assign w_win_idx  = c_TAPW'(r_fs - 1'b1) - r_tap;
    assign w_x        = r_win[w_win_idx];
    assign w_filt_we  = (r_state == ST_IDLE) && filt_wen;

    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign error       = r_error;
    assign result_idx  = r_idx;
    assign result_data = result_valid ? w_acc[r_idx] : '0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake/control decode.
    always_comb begin
        w_next       = r_state;
        ifmap_ready  = 1'b0;
        psum_ready   = 1'b0;
        result_valid = 1'b0;
        w_clear      = 1'b0;
        w_mac_en     = 1'b0;
        w_psum_en    = 1'b0;
        w_done_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && w_cfg_ok) begin
                    w_next = ST_FILL;
                end
            end
            ST_FILL: begin
                ifmap_ready = 1'b1;
                if (w_win_done) begin
                    w_next  = ST_MAC;
                    w_clear = 1'b1;
                end else if (w_accept && ifmap_last) begin
                    w_next     = ST_IDLE;
                    w_done_set = 1'b1;
                end
            end
            ST_MAC: begin
                w_mac_en = 1'b1;
                if (w_tap_last) begin
                    w_next = r_psum_mode ? ST_PSUM : ST_OUT;
                end
            end
            ST_PSUM: begin
                psum_ready = 1'b1;
                if (psum_valid) begin
                    w_psum_en = 1'b1;
                    if (w_idx_last) begin
                        w_next = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                result_valid = 1'b1;
                if (result_ready && w_idx_last) begin
                    if (r_row_last) begin
                        w_next     = ST_IDLE;
                        w_done_set = 1'b1;
                    end else begin
                        w_next = ST_FILL;
                    end
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Configuration latch, fill/stride/tap/beat counters and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fs        <= '0;
            r_stride    <= '0;
            r_psum_mode <= 1'b0;
            r_fill      <= '0;
            r_skip      <= '0;
            r_tap       <= '0;
            r_idx       <= '0;
            r_row_last  <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_done <= w_done_set;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_cfg_ok) begin
                            r_fs        <= filter_size;
                            r_stride    <= stride;
                            r_psum_mode <= psum_mode;
                            r_fill      <= '0;
                            r_skip      <= '0;
                            r_tap       <= '0;
                            r_idx       <= '0;
                            r_row_last  <= 1'b0;
                            r_error     <= 1'b0;
                        end else begin
                            r_error     <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    if (w_accept) begin
                        r_fill <= w_fill_nxt;
                        r_skip <= w_skip_nxt;
                        if (w_win_done) begin
                            r_row_last <= ifmap_last;
                            r_tap      <= '0;
                        end
                    end
                end
                ST_MAC: begin
                    r_tap <= r_tap + 1'b1;
                    if (w_tap_last) begin
                        r_idx <= '0;
                    end
                end
                ST_PSUM: begin
                    if (psum_valid) begin
                        r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (result_ready) begin
                        r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
                        // Next window needs 'stride' fresh elements.
                        if (w_idx_last && !r_row_last) begin
                            r_skip <= r_stride;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Sliding window shift register, advanced on each accepted element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_FILTER_SIZE; i++) begin
                r_win[i] <= '0;
            end
        end else if (w_accept) begin
            r_win[0] <= ifmap_data;
            for (int i = 1; i < MAX_FILTER_SIZE; i++) begin
                r_win[i] <= r_win[i-1];
            end
        end
    end

    generate
        for (genvar f = 0; f < NUM_FILTERS; f++) begin : g_lane
            conv_mac_lane #(
                .DATA_WIDTH      (DATA_WIDTH),
                .ACC_WIDTH       (ACC_WIDTH),
                .MAX_FILTER_SIZE (MAX_FILTER_SIZE)
            ) u_lane (
                .clk       (clk),
                .rst_n     (rst_n),
                .tap_wen   (w_filt_we && (filt_idx == c_IDXW'(f))),
                .tap_addr  (filt_tap),
                .tap_data  (filt_data),
                .clear     (w_clear),
                .mac_en    (w_mac_en),
                .tap_sel   (r_tap),
                .x_data    (w_x),
                .psum_en   (w_psum_en && (r_idx == c_IDXW'(f))),
                .psum_data (psum_data),
                .acc       (w_acc[f])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_conv1d_multi_filter_engine.sv
// ============================================================================
// Module      : tb_conv1d_multi_filter_engine
// Description : Directed self-checking bench for conv1d_multi_filter_engine.
//               A second instance with ACC_WIDTH=16 shares the stimulus and
//               covers accumulator overflow (CONV_SAT_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_conv1d_multi_filter_engine;

    localparam int AW = 20;

`ifdef CONV_SAT_EN
    localparam int c_EXP16 = 32767;
`else
    localparam int c_EXP16 = -17149;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [3:0]           stride;
    logic [3:0]           filter_size;
    logic                 psum_mode;
    logic                 filt_wen;
    logic [1:0]           filt_idx;
    logic [2:0]           filt_tap;
    logic [7:0]           filt_data;
    logic [7:0]           ifmap_data;
    logic                 ifmap_valid;
    logic                 ifmap_last;
    logic                 ifmap_ready;
    logic [AW-1:0]        psum_data;
    logic                 psum_valid;
    logic                 psum_ready;
    logic signed [AW-1:0] result_data;
    logic [1:0]           result_idx;
    logic                 result_valid;
    logic                 result_ready;
    logic                 busy;
    logic                 done;
    logic                 error;

    logic                 s16_ifmap_ready;
    logic                 s16_psum_ready;
    logic signed [15:0]   s16_result_data;
    logic [1:0]           s16_result_idx;
    logic                 s16_result_valid;
    logic                 s16_busy;
    logic                 s16_done;
    logic                 s16_error;

    int checks = 0;
    int errors = 0;

    int q_idx[$];
    int q_dat[$];
    int q16[$];
    int done_cnt = 0;
    int psum_vals[4] = '{10, 20, 30, 40};
    int psum_ptr = 0;
    bit psum_hs = 1'b0;

    always #5 clk = ~clk;

    conv1d_multi_filter_engine u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stride       (stride),
        .filter_size  (filter_size),
        .psum_mode    (psum_mode),
        .filt_wen     (filt_wen),
        .filt_idx     (filt_idx),
        .filt_tap     (filt_tap),
        .filt_data    (filt_data),
        .ifmap_data   (ifmap_data),
        .ifmap_valid  (ifmap_valid),
        .ifmap_last   (ifmap_last),
        .ifmap_ready  (ifmap_ready),
        .psum_data    (psum_data),
        .psum_valid   (psum_valid),
        .psum_ready   (psum_ready),
        .result_data  (result_data),
        .result_idx   (result_idx),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    conv1d_multi_filter_engine #(.ACC_WIDTH(16)) u_dut16 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stride       (stride),
        .filter_size  (filter_size),
        .psum_mode    (psum_mode),
        .filt_wen     (filt_wen),
        .filt_idx     (filt_idx),
        .filt_tap     (filt_tap),
        .filt_data    (filt_data),
        .ifmap_data   (ifmap_data),
        .ifmap_valid  (ifmap_valid),
        .ifmap_last   (ifmap_last),
        .ifmap_ready  (s16_ifmap_ready),
        .psum_data    (psum_data[15:0]),
        .psum_valid   (psum_valid),
        .psum_ready   (s16_psum_ready),
        .result_data  (s16_result_data),
        .result_idx   (s16_result_idx),
        .result_valid (s16_result_valid),
        .result_ready (result_ready),
        .busy         (s16_busy),
        .done         (s16_done),
        .error        (s16_error)
    );

    assign psum_data = AW'(psum_vals[psum_ptr % 4]);

    // Observe handshakes mid-cycle; inputs only change just after posedge.
    always @(negedge clk) begin
        if (psum_hs) psum_ptr = psum_ptr + 1;
        psum_hs = psum_ready && psum_valid;
        if (result_valid && result_ready) begin
            q_idx.push_back(int'(result_idx));
            q_dat.push_back(int'(result_data));
        end
        if (s16_result_valid && result_ready) begin
            q16.push_back(int'(s16_result_data));
        end
        if (done) done_cnt = done_cnt + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_queues();
        q_idx.delete();
        q_dat.delete();
        q16.delete();
    endtask

    task automatic write_tap(input int f, input int t, input int d);
        filt_wen  = 1'b1;
        filt_idx  = 2'(f);
        filt_tap  = 3'(t);
        filt_data = 8'(d);
        tick();
        filt_wen  = 1'b0;
    endtask

    task automatic write_lane(input int f, input int a, input int b, input int c);
        write_tap(f, 0, a);
        write_tap(f, 1, b);
        write_tap(f, 2, c);
    endtask

    task automatic do_start(input int fs, input int st, input bit pm);
        start       = 1'b1;
        filter_size = 4'(fs);
        stride      = 4'(st);
        psum_mode   = pm;
        tick();
        start       = 1'b0;
    endtask

    task automatic send_x(input int d, input bit last);
        int n = 0;
        while (!ifmap_ready && n < 200) begin
            tick();
            n++;
        end
        if (!ifmap_ready) begin
            checks++;
            errors++;
            $display("FAIL send_x timeout: ifmap_ready=%0b required 1", ifmap_ready);
        end else begin
            ifmap_valid = 1'b1;
            ifmap_data  = 8'(d);
            ifmap_last  = last;
            tick();
            ifmap_valid = 1'b0;
            ifmap_last  = 1'b0;
        end
    endtask

    task automatic send_row(input int n);
        for (int v = 1; v <= n; v++) send_x(v, v == n);
    endtask

    task automatic wait_done(input string name, input int base);
        int n = 0;
        while (done_cnt == base && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt != base + 1) begin
            errors++;
            $display("FAIL %s done: pulses=%0d required %0d", name, done_cnt - base, 1);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, error, ifmap_ready, psum_ready, result_valid} !== 6'b0) begin
            errors++;
            $display("FAIL reset flags: busy/done/err/ird/prd/rv=%b required 000000",
                     {busy, done, error, ifmap_ready, psum_ready, result_valid});
        end
        checks++;
        if (result_data !== '0 || result_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset result: data=%0d idx=%0d required 0 0", result_data, result_idx);
        end
    endtask

    task automatic test_stride1();
        int exp_d[8] = '{6, -2, 2, -3, 9, -2, 4, -4};
        int base = done_cnt;
        int n = 0;
        clear_queues();
        write_lane(0, 1, 1, 1);
        write_lane(1, 1, 0, -1);
        write_lane(2, 2, 0, 0);
        write_lane(3, 0, 0, -1);
        do_start(3, 1, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL stride1 busy: busy=%0b required 1", busy);
        end
        send_x(1, 1'b0);
        send_x(2, 1'b0);
        send_x(3, 1'b0);
        while (!result_valid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL stride1 latency: cycles after MAC start=%0d required 3", n);
        end
        send_x(4, 1'b1);
        wait_done("stride1", base);
        checks++;
        if (q_dat.size() != 8) begin
            errors++;
            $display("FAIL stride1 count: results=%0d required 8", q_dat.size());
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= q_dat.size() || q_dat[i] !== exp_d[i] || q_idx[i] !== i % 4) begin
                errors++;
                $display("FAIL stride1 result[%0d]: got (%0d,%0d) required (%0d,%0d)", i,
                         (i < q_idx.size()) ? q_idx[i] : -1, (i < q_dat.size()) ? q_dat[i] : -1,
                         i % 4, exp_d[i]);
            end
        end
    endtask

    task automatic test_stride2();
        int exp_d[8] = '{6, -2, 2, -3, 12, -2, 6, -5};
        for (int run = 0; run < 2; run++) begin
            int base = done_cnt;
            clear_queues();
            do_start(3, 2, 1'b0);
            send_row(5 + run);
            wait_done("stride2", base);
            checks++;
            if (q_dat.size() != 8) begin
                errors++;
                $display("FAIL stride2 count run%0d: results=%0d required 8", run, q_dat.size());
            end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (i >= q_dat.size() || q_dat[i] !== exp_d[i]) begin
                    errors++;
                    $display("FAIL stride2 run%0d result[%0d]: got %0d required %0d", run, i,
                             (i < q_dat.size()) ? q_dat[i] : -1, exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_psum();
        int exp_d[8] = '{16, 18, 32, 37, 22, 18, 36, 35};
        int base = done_cnt;
        clear_queues();
        psum_ptr   = 0;
        psum_hs    = 1'b0;
        psum_valid = 1'b1;
        do_start(3, 2, 1'b1);
        send_row(5);
        wait_done("psum", base);
        psum_valid = 1'b0;
        checks++;
        if (q_dat.size() != 8) begin
            errors++;
            $display("FAIL psum count: results=%0d required 8", q_dat.size());
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= q_dat.size() || q_dat[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL psum result[%0d]: got %0d required %0d", i,
                         (i < q_dat.size()) ? q_dat[i] : -1, exp_d[i]);
            end
        end
    endtask

    task automatic test_saturation();
        int exp20[4] = '{48387, 0, 254, -127};
        int exp16[4] = '{c_EXP16, 0, 254, -127};
        int base = done_cnt;
        clear_queues();
        write_lane(0, 127, 127, 127);
        do_start(3, 1, 1'b0);
        send_x(127, 1'b0);
        send_x(127, 1'b0);
        send_x(127, 1'b1);
        wait_done("sat", base);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= q_dat.size() || q_dat[i] !== exp20[i]) begin
                errors++;
                $display("FAIL sat acc20[%0d]: got %0d required %0d", i,
                         (i < q_dat.size()) ? q_dat[i] : -1, exp20[i]);
            end
            checks++;
            if (i >= q16.size() || q16[i] !== exp16[i]) begin
                errors++;
                $display("FAIL sat acc16[%0d]: got %0d required %0d", i,
                         (i < q16.size()) ? q16[i] : -1, exp16[i]);
            end
        end
        write_lane(0, 1, 1, 1);
    endtask

    task automatic test_config_error();
        int base = done_cnt;
        clear_queues();
        do_start(3, 0, 1'b0);
        checks++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cfg stride0: error=%0b busy=%0b required 1 0", error, busy);
        end
        do_start(9, 1, 1'b0);
        checks++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cfg fs9: error=%0b busy=%0b required 1 0", error, busy);
        end
        do_start(3, 1, 1'b0);
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL cfg clear: error=%0b busy=%0b required 0 1", error, busy);
        end
        send_x(1, 1'b1);
        wait_done("cfg short row", base);
        checks++;
        if (q_dat.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cfg short row: results=%0d busy=%0b required 0 0", q_dat.size(), busy);
        end
    endtask

    task automatic test_backpressure();
        int exp_d[4] = '{6, -2, 2, -3};
        int base = done_cnt;
        int n = 0;
        logic signed [AW-1:0] d0;
        clear_queues();
        result_ready = 1'b0;
        do_start(3, 1, 1'b0);
        send_row(3);
        while (!result_valid && n < 20) begin
            tick();
            n++;
        end
        d0 = result_data;
        checks++;
        if (d0 !== AW'(6) || result_idx !== 2'd0) begin
            errors++;
            $display("FAIL bp first: data=%0d idx=%0d required 6 0", d0, result_idx);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (result_valid !== 1'b1 || result_data !== d0 || result_idx !== 2'd0) begin
                errors++;
                $display("FAIL bp hold cycle%0d: valid=%0b data=%0d idx=%0d required 1 6 0",
                         c, result_valid, result_data, result_idx);
            end
        end
        result_ready = 1'b1;
        wait_done("bp", base);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= q_dat.size() || q_dat[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL bp result[%0d]: got %0d required %0d", i,
                         (i < q_dat.size()) ? q_dat[i] : -1, exp_d[i]);
            end
        end
    endtask

    task automatic test_reset_mid_mac();
        int exp_d[8] = '{6, -2, 2, -3, 9, -2, 4, -4};
        int base;
        clear_queues();
        do_start(3, 1, 1'b0);
        send_row(3);
        base = done_cnt;
        rst_n = 1'b0;
        tick();
        checks++;
        if ({busy, done, error, ifmap_ready, psum_ready, result_valid} !== 6'b0 ||
            result_data !== '0 || result_idx !== 2'd0) begin
            errors++;
            $display("FAIL rst mid: flags=%b data=%0d idx=%0d required 000000 0 0",
                     {busy, done, error, ifmap_ready, psum_ready, result_valid},
                     result_data, result_idx);
        end
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (done_cnt != base || q_dat.size() != 0) begin
            errors++;
            $display("FAIL rst abort: done=%0d results=%0d required 0 0",
                     done_cnt - base, q_dat.size());
        end
        base = done_cnt;
        do_start(3, 1, 1'b0);
        send_row(4);
        wait_done("rst restart", base);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= q_dat.size() || q_dat[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL rst restart result[%0d]: got %0d required %0d", i,
                         (i < q_dat.size()) ? q_dat[i] : -1, exp_d[i]);
            end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        stride       = '0;
        filter_size  = '0;
        psum_mode    = 1'b0;
        filt_wen     = 1'b0;
        filt_idx     = '0;
        filt_tap     = '0;
        filt_data    = '0;
        ifmap_data   = '0;
        ifmap_valid  = 1'b0;
        ifmap_last   = 1'b0;
        psum_valid   = 1'b0;
        result_ready = 1'b1;
        tick();
        tick();
        tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_stride1();
        test_stride2();
        test_psum();
        test_saturation();
        test_config_error();
        test_backpressure();
        test_reset_mid_mac();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
